// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: holds the PLL in reset, waits for a debounced lock, then releases the downstream reset.
// Re-sequences with bounded retries on lock timeout or loss of lock.
module pll_lock_sequencer #(
   parameter int RST_CYCLES   = 16,
   parameter int LOCK_STABLE  = 1024,
   parameter int LOCK_TIMEOUT = 1000000,
   parameter int MAX_RETRIES  = 3,
   parameter int LOSS_FILTER  = 2
) (
   input  logic       refclk,
   input  logic       rst_n,
   input  logic       pll_locked,
   input  logic       req_relock,
   output logic       pll_rst,
   output logic       sys_rst_n,
   output logic       ready,
   output logic       fault,
   output logic [3:0] retry_cnt,
   output logic [7:0] lost_lock_cnt
);
   typedef enum logic [1:0] {ASSERT, WAIT, RUN, FAULT} state_t;
   localparam int RW = $clog2(RST_CYCLES + 1);
   localparam int SW = $clog2(LOCK_STABLE + 1);
   localparam int TW = $clog2(LOCK_TIMEOUT + 1);
   localparam int LW = $clog2(LOSS_FILTER + 1);
   state_t state, nxt;
   logic [1:0] sync;
   logic locked_s, rst_done, lock_done, timed_out, lost;
   logic [RW-1:0] rst_cnt;
   logic [SW-1:0] stable;
   logic [TW-1:0] tmo;
   logic [LW-1:0] loss;
   assign locked_s  = sync[1];
   assign rst_done  = rst_cnt == RW'(RST_CYCLES - 1);
   assign lock_done = locked_s && stable == SW'(LOCK_STABLE - 1);
   assign timed_out = tmo == TW'(LOCK_TIMEOUT - 1);
   assign lost      = !locked_s && loss == LW'(LOSS_FILTER - 1);
   // Lock completion outranks timeout; relock request outranks both.
   always_comb
      nxt = req_relock ? ASSERT :
            state == ASSERT ? (rst_done ? WAIT : ASSERT) :
            state == WAIT ? (lock_done ? RUN :
                             timed_out ? (retry_cnt + 4'd1 == 4'(MAX_RETRIES) ? FAULT : ASSERT) : WAIT) :
            state == RUN ? (lost ? ASSERT : RUN) : FAULT;
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         sync          <= '0;
         state         <= ASSERT;
         pll_rst       <= 1'b1;
         sys_rst_n     <= 1'b0;
         ready         <= 1'b0;
         fault         <= 1'b0;
         retry_cnt     <= '0;
         lost_lock_cnt <= '0;
         rst_cnt       <= '0;
         stable        <= '0;
         tmo           <= '0;
         loss          <= '0;
      end else begin
         sync      <= {sync[0], pll_locked};
         state     <= nxt;
         pll_rst   <= nxt == ASSERT || nxt == FAULT;
         sys_rst_n <= nxt == RUN;
         ready     <= nxt == RUN;
         fault     <= nxt == FAULT;
         rst_cnt   <= (state == ASSERT && nxt == ASSERT && !req_relock) ? rst_cnt + 1'b1 : '0;
         stable    <= (state == WAIT && nxt == WAIT && locked_s) ? stable + 1'b1 : '0;
         tmo       <= (state == WAIT && nxt == WAIT) ? tmo + 1'b1 : '0;
         loss      <= (state == RUN && nxt == RUN && !locked_s) ? loss + 1'b1 : '0;
         retry_cnt <= req_relock ? '0 :
                      (state == WAIT && !lock_done && timed_out) ? retry_cnt + 4'd1 :
                      (state == RUN && lost) ? '0 : retry_cnt;
         if (state == RUN && lost && !req_relock && lost_lock_cnt != 8'hFF)
            lost_lock_cnt <= lost_lock_cnt + 8'd1;
      end
   end
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed checks of acquisition, glitch, timeout, loss, relock, reset and saturation.
module tb_pll_lock_sequencer;
   logic refclk = 1'b0;
   logic rst_n = 1'b1;
   logic pll_locked = 1'b0;
   logic req_relock = 1'b0;
   logic pll_rst, sys_rst_n, ready, fault;
   logic [3:0] retry_cnt;
   logic [7:0] lost_lock_cnt;
   int passed = 0;
   int total = 0;

   pll_lock_sequencer #(
      .RST_CYCLES(4), .LOCK_STABLE(8), .LOCK_TIMEOUT(32), .MAX_RETRIES(2), .LOSS_FILTER(2)
   ) dut (
      .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .req_relock(req_relock),
      .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .ready(ready), .fault(fault),
      .retry_cnt(retry_cnt), .lost_lock_cnt(lost_lock_cnt)
   );

   always #5 refclk = ~refclk;

   task automatic tick(input int n);
      repeat (n) @(posedge refclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // After return, the next rising edge is edge 1.
   task automatic do_reset(input logic locked);
      rst_n = 1'b0;
      pll_locked = locked;
      req_relock = 1'b0;
      tick(3);
      rst_n = 1'b1;
   endtask

   initial begin
      #2;
      do_reset(1'b1);
      check("rst_pll_rst", 8'(pll_rst), 8'd1);
      check("rst_sys_rst_n", 8'(sys_rst_n), 8'd0);
      check("rst_ready", 8'(ready), 8'd0);
      check("rst_fault", 8'(fault), 8'd0);
      check("rst_retry", 8'(retry_cnt), 8'd0);
      check("rst_lost", lost_lock_cnt, 8'd0);
      // normal lock
      tick(3);
      check("norm_pll_rst_e3", 8'(pll_rst), 8'd1);
      tick(1);
      check("norm_pll_rst_e4", 8'(pll_rst), 8'd0);
      tick(7);
      check("norm_ready_e11", 8'(ready), 8'd0);
      tick(1);
      check("norm_ready_e12", 8'(ready), 8'd1);
      check("norm_sys_rst_n_e12", 8'(sys_rst_n), 8'd1);
      check("norm_retry", 8'(retry_cnt), 8'd0);
      // single-cycle low in RUN is filtered
      pll_locked = 1'b0;
      tick(1);
      pll_locked = 1'b1;
      tick(5);
      check("blip_ready", 8'(ready), 8'd1);
      check("blip_lost", lost_lock_cnt, 8'd0);
      // three-cycle low causes loss
      pll_locked = 1'b0;
      tick(3);
      check("loss_ready_e3", 8'(ready), 8'd1);
      pll_locked = 1'b1;
      tick(1);
      check("loss_ready_e4", 8'(ready), 8'd0);
      check("loss_sys_rst_n_e4", 8'(sys_rst_n), 8'd0);
      check("loss_pll_rst_e4", 8'(pll_rst), 8'd1);
      check("loss_lost_e4", lost_lock_cnt, 8'd1);
      check("loss_retry_e4", 8'(retry_cnt), 8'd0);
      tick(11);
      check("loss_relock_early", 8'(ready), 8'd0);
      tick(1);
      check("loss_relock", 8'(ready), 8'd1);
      // glitch during WAIT restarts the stable count
      do_reset(1'b1);
      tick(6);
      pll_locked = 1'b0;
      tick(1);
      pll_locked = 1'b1;
      tick(5);
      check("glitch_ready_e12", 8'(ready), 8'd0);
      tick(4);
      check("glitch_ready_e16", 8'(ready), 8'd0);
      tick(1);
      check("glitch_ready_e17", 8'(ready), 8'd1);
      // timeouts to FAULT
      do_reset(1'b0);
      tick(35);
      check("tmo_retry_e35", 8'(retry_cnt), 8'd0);
      check("tmo_pll_rst_e35", 8'(pll_rst), 8'd0);
      tick(1);
      check("tmo_retry_e36", 8'(retry_cnt), 8'd1);
      check("tmo_pll_rst_e36", 8'(pll_rst), 8'd1);
      check("tmo_fault_e36", 8'(fault), 8'd0);
      tick(35);
      check("tmo_fault_e71", 8'(fault), 8'd0);
      tick(1);
      check("tmo_fault_e72", 8'(fault), 8'd1);
      check("tmo_retry_e72", 8'(retry_cnt), 8'd2);
      check("tmo_pll_rst_e72", 8'(pll_rst), 8'd1);
      tick(10);
      check("fault_hold", 8'(fault), 8'd1);
      check("fault_pll_rst_hold", 8'(pll_rst), 8'd1);
      // recovery from FAULT
      req_relock = 1'b1;
      tick(1);
      req_relock = 1'b0;
      check("relock_fault", 8'(fault), 8'd0);
      check("relock_retry", 8'(retry_cnt), 8'd0);
      check("relock_pll_rst", 8'(pll_rst), 8'd1);
      tick(36);
      check("relock_retry_again", 8'(retry_cnt), 8'd1);
      // async reset mid-WAIT
      tick(6);
      check("midwait_pll_rst", 8'(pll_rst), 8'd0);
      #2 rst_n = 1'b0;
      #1;
      check("async_pll_rst", 8'(pll_rst), 8'd1);
      check("async_retry", 8'(retry_cnt), 8'd0);
      check("async_sys_rst_n", 8'(sys_rst_n), 8'd0);
      // req_relock coincident with lock completion
      do_reset(1'b1);
      tick(11);
      req_relock = 1'b1;
      tick(1);
      req_relock = 1'b0;
      check("prio_ready", 8'(ready), 8'd0);
      check("prio_pll_rst", 8'(pll_rst), 8'd1);
      tick(11);
      check("prio_ready_early", 8'(ready), 8'd0);
      tick(1);
      check("prio_ready_relock", 8'(ready), 8'd1);
      // loss counter saturation
      do_reset(1'b1);
      tick(12);
      check("sat_start_ready", 8'(ready), 8'd1);
      for (int i = 0; i < 300; i++) begin
         pll_locked = 1'b0;
         tick(3);
         pll_locked = 1'b1;
         tick(13);
         if (i == 9) check("sat_lost_10", lost_lock_cnt, 8'd10);
         if (i == 254) check("sat_lost_255", lost_lock_cnt, 8'd255);
      end
      check("sat_lost_300", lost_lock_cnt, 8'd255);
      check("sat_ready", 8'(ready), 8'd1);
      req_relock = 1'b1;
      tick(1);
      req_relock = 1'b0;
      check("sat_lost_after_relock", lost_lock_cnt, 8'd255);
      check("sat_ready_after_relock", 8'(ready), 8'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
